sseg_scan_controller: RTL and testbench
=======================================

// Module: sseg_scan_controller
// PURPOSE
//  Parametrised N-digit time-multiplexed seven-segment driver for PS/2 keycode display.
//  Latches a hex word on a load event, scans enabled digits at a divided rate, and
//  emits a fixed-length, retriggerable strobe per load. Sits between the PS/2 decoder
//  (data + key-release) and the board anode/segment pins.
// PARAMETERS
//  NUM_DIGITS  4        number of digits / anodes (1..8)
//  SCAN_DIV    262144   clk cycles per digit slot (>=2)
//  STROBE_LEN  1000000  strobe high time in clk cycles (>=1)
//  ACTIVE_LOW  1        1: an/sseg active-low (board default); 0: active-high
// PORTS
//  clk       in   1             system clock
//  rst_n     in   1             synchronous reset, active-low
//  data      in   4*NUM_DIGITS  hex nibbles; data[3:0] = digit 0 (rightmost)
//  digit_en  in   NUM_DIGITS    per-digit enable; 0 = digit blanked
//  load      in   1             level input (key release); rising edge = load event
//  an        out  NUM_DIGITS    anode select, one-hot active, registered
//  sseg      out  7             segments {a,b,c,d,e,f,g}, registered
//  strobe    out  1             load-acknowledge pulse, registered
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
//  - Reset: an/sseg all inactive (all 1s if ACTIVE_LOW), strobe=0, shadow=0, digit idx=0,
//    scan cnt=0, strobe cnt=0, load edge reg=0, state=IDLE. Reset mid-scan/mid-strobe
//    aborts immediately; state change visible the cycle after rst_n sampled low.
//  - Load event: load=1 while registered load_d=0. Event at edge t -> shadow<=data and
//    strobe=1 from t+1. Level held high = single event only.
//  - FSM: IDLE: outputs blank, scan cnt held at 0; first load event -> SCAN.
//    SCAN: never returns to IDLE except via reset.
//  - Scan: cnt counts 0..SCAN_DIV-1 then wraps; tick when cnt==SCAN_DIV-1. On tick
//    idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, and an/sseg reload for new idx.
//    Entry to SCAN: first display is idx 0 at t+1 (same edge shadow updates).
//  - Digit output: nibble=shadow[4*idx+:4]; enabled -> an active at bit idx only,
//    sseg = hex pattern (active-low table 0->0000001, 8->0000000, F->0111000);
//    disabled (digit_en[idx]=0) -> all an inactive, sseg all off, slot time still used.
//  - ACTIVE_LOW=0 inverts an and sseg at the output register only.
//  - Simultaneous load event and tick: new shadow written; an/sseg for the new idx use
//    the new shadow value (bypass), so no stale digit is displayed.
//  - digit_en is sampled live at each tick, not latched with data.
//  - Strobe: counter 0..STROBE_LEN-1; strobe high exactly STROBE_LEN cycles, then 0.
//    Load event while strobe high restarts count -> high STROBE_LEN cycles from the new
//    event. Counter width $clog2(STROBE_LEN+1); no wrap while idle (held).
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined: at each tick, digit idx>0 is blanked (as disabled) if its
//    nibble and all higher nibbles in shadow are 0; digit 0 always shown if enabled.
//  Undefined: every enabled digit shows its nibble, including leading zeros.
// TESTING (bench params NUM_DIGITS=4, SCAN_DIV=4, STROBE_LEN=10, ACTIVE_LOW=1)
//  1 Reset: rst_n=0 2 cycles -> an=4'b1111, sseg=7'b1111111, strobe=0; no load -> stays blank.
//  2 data=16'h12AF, digit_en=4'hF, load 0->1 -> strobe high 10 cycles exactly; an cycles
//    1110,1101,1011,0111 every 4 clks with sseg 0111000,0001000,0010010,1001111.
//  3 Retrigger: second load edge 6 cycles into strobe -> strobe stays high, falls 10
//    cycles after the second edge (16 total); load held high 50 cycles -> no further strobe.
//  4 digit_en=4'b0101 -> slots 1,3 show an=1111/sseg=1111111; slots 0,2 normal; period 16.
//  5 LEAD_ZERO_BLANK_EN, data=16'h0005 -> only an=1110 with sseg=0100100; data=16'h0000
//    -> digit 0 shows 0000001. Without macro, 16'h0005 -> all four digits lit.
//  6 rst_n=0 mid-strobe and mid-scan -> next cycle all outputs at reset values; IDLE until new load.

Source files
------------

// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller
// N-digit time-multiplexed seven-segment driver for PS/2 keycode display.
// A rising edge on `load` latches `data` into a shadow word and fires a
// fixed-length, retriggerable `strobe`. Once the first load has happened,
// the enabled digits are scanned round-robin, one slot every SCAN_DIV clocks.
//
// Build option: define LEAD_ZERO_BLANK_EN to blank leading-zero digits.
// Digit 0 is always shown when it is enabled. With the macro undefined,
// every enabled digit shows its nibble.

module sseg_scan_controller #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 262144,
   parameter int STROBE_LEN = 1000000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              sseg,
   output logic                    strobe
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W  = $clog2(SCAN_DIV);
   localparam int SCNT_W = $clog2(STROBE_LEN + 1);

   localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SCAN_DIV - 1);
   localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STROBE_LEN - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;

   // Segment pattern {a,b,c,d,e,f,g}, 1 = segment lit (polarity applied later)
   function automatic logic [6:0] hex_segs(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   // Board polarity is applied only at the output registers
   function automatic logic [NUM_DIGITS-1:0] pol_an(input logic [NUM_DIGITS-1:0] v);
      return (ACTIVE_LOW != 0) ? ~v : v;
   endfunction

   function automatic logic [6:0] pol_seg(input logic [6:0] v);
      return (ACTIVE_LOW != 0) ? ~v : v;
   endfunction

   logic [0:0]              state;
   logic                    load_d;
   logic [CNT_W-1:0]        scan_cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [SCNT_W-1:0]       strb_cnt;

   logic                    load_evt;
   logic                    tick;
   logic                    disp_upd;
   logic [4*NUM_DIGITS-1:0] shadow_nxt;
   logic [IDX_W-1:0]        idx_wrap;
   logic [IDX_W-1:0]        idx_nxt;
   logic [3:0]              nibble;
   logic                    en_sel;
   logic                    lead_blank;
   logic                    show;
   logic [NUM_DIGITS-1:0]   an_on;
   logic [6:0]              seg_on;
`ifdef LEAD_ZERO_BLANK_EN
   logic                    hz;
`endif

   // Next-display selection; a load on a tick edge bypasses the new word to the display
   always_comb begin
      load_evt   = load & ~load_d;
      tick       = (state == SCAN) && (scan_cnt == CNT_MAX);
      shadow_nxt = load_evt ? data : shadow;
      idx_wrap   = (idx == IDX_MAX) ? '0 : idx + 1'b1;
      idx_nxt    = (state == IDLE) ? '0 : (tick ? idx_wrap : idx);
      disp_upd   = (state == IDLE) ? load_evt : tick;
      nibble     = 4'h0;
      en_sel     = 1'b0;
      lead_blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
      hz         = 1'b1;
`endif
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef LEAD_ZERO_BLANK_EN
         hz = hz & (shadow_nxt[4*i +: 4] == 4'h0);
`endif
         if (idx_nxt == IDX_W'(i)) begin
            nibble = shadow_nxt[4*i +: 4];
            en_sel = digit_en[i];
`ifdef LEAD_ZERO_BLANK_EN
            lead_blank = hz && (i != 0);
`endif
         end
      end
      show  = en_sel & ~lead_blank;
      an_on = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_on[i] = show && (idx_nxt == IDX_W'(i));
      end
      seg_on = show ? hex_segs(nibble) : 7'b0000000;
   end

   // Control: load edge detect, IDLE/SCAN state, slot counter, digit index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         load_d   <= 1'b0;
         scan_cnt <= '0;
         idx      <= '0;
      end else begin
         load_d <= load;
         idx    <= idx_nxt;
         if (state == IDLE) begin
            scan_cnt <= '0;
            if (load_evt) state <= SCAN;
         end else begin
            scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
         end
      end
   end

   // Shadow word latched on each load event
   always_ff @(posedge clk) begin
      if (!rst_n) shadow <= '0;
      else        shadow <= shadow_nxt;
   end

   // Registered anode/segment outputs, reloaded on SCAN entry and every slot tick
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an   <= pol_an('0);
         sseg <= pol_seg(7'b0000000);
      end else if (disp_upd) begin
         an   <= pol_an(an_on);
         sseg <= pol_seg(seg_on);
      end
   end

   // Retriggerable strobe: high for STROBE_LEN cycles after the most recent load event
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         strobe   <= 1'b0;
         strb_cnt <= '0;
      end else if (load_evt) begin
         strobe   <= 1'b1;
         strb_cnt <= '0;
      end else if (strobe) begin
         if (strb_cnt == SCNT_MAX) strobe <= 1'b0;
         else                      strb_cnt <= strb_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller (NUM_DIGITS=4, SCAN_DIV=4, STROBE_LEN=10,
// ACTIVE_LOW=1). Expectations follow LEAD_ZERO_BLANK_EN when it is defined.

module tb_sseg_scan_controller;

   logic        clk;
   logic        rst_n;
   logic [15:0] data;
   logic [3:0]  digit_en;
   logic        load;
   logic [3:0]  an;
   logic [6:0]  sseg;
   logic        strobe;

   int tests;
   int fails;

   localparam logic [6:0] S_OFF = 7'b1111111;
   localparam logic [6:0] S_0   = 7'b0000001;
   localparam logic [6:0] S_1   = 7'b1001111;
   localparam logic [6:0] S_2   = 7'b0010010;
   localparam logic [6:0] S_3   = 7'b0000110;
   localparam logic [6:0] S_4   = 7'b1001100;
   localparam logic [6:0] S_5   = 7'b0100100;
   localparam logic [6:0] S_A   = 7'b0001000;
   localparam logic [6:0] S_F   = 7'b0111000;

   sseg_scan_controller #(
      .NUM_DIGITS(4),
      .SCAN_DIV(4),
      .STROBE_LEN(10),
      .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data(data),
      .digit_en(digit_en),
      .load(load),
      .an(an),
      .sseg(sseg),
      .strobe(strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      step();
      step();
      tests++;
      if (an !== 4'b1111 || sseg !== S_OFF || strobe !== 1'b0) begin
         fails++;
         $display("FAIL reset: an=%b sseg=%b strobe=%b, want 1111 1111111 0", an, sseg, strobe);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         tests++;
         if (an !== 4'b1111 || sseg !== S_OFF || strobe !== 1'b0) begin
            fails++;
            $display("FAIL idle_blank cyc %0d: an=%b sseg=%b strobe=%b, want 1111 1111111 0",
                     i, an, sseg, strobe);
         end
      end
   endtask

   task automatic test_scan_basic();
      logic [3:0] ea;
      logic [6:0] es [4];
      int         k;
      es[0] = S_F; es[1] = S_A; es[2] = S_2; es[3] = S_1;
      do_reset();
      data     = 16'h12AF;
      digit_en = 4'hF;
      load     = 1'b1;
      step();
      for (int i = 0; i < 17; i++) begin
         if (i > 0) step();
         k  = (i / 4) % 4;
         ea = 4'b1111;
         ea[k] = 1'b0;
         tests++;
         if (an !== ea || sseg !== es[k] || strobe !== (i < 10)) begin
            fails++;
            $display("FAIL scan_basic cyc %0d: an=%b sseg=%b strobe=%b, want %b %b %b",
                     i, an, sseg, strobe, ea, es[k], (i < 10));
         end
      end
      load = 1'b0;
   endtask

   task automatic test_retrigger();
      int highs;
      do_reset();
      data     = 16'h12AF;
      digit_en = 4'hF;
      load     = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i > 0) step();
         if (i == 5) load = 1'b1;
         tests++;
         if (strobe !== (i < 16)) begin
            fails++;
            $display("FAIL retrigger cyc %0d: strobe=%b, want %b", i, strobe, (i < 16));
         end
      end
      highs = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (strobe === 1'b1) highs++;
      end
      tests++;
      if (highs != 0) begin
         fails++;
         $display("FAIL load_held: strobe high %0d cycles, want 0", highs);
      end
      load = 1'b0;
   endtask

   task automatic test_digit_en();
      logic [3:0] ea;
      logic [6:0] es [4];
      int         k;
      es[0] = S_F; es[1] = S_OFF; es[2] = S_2; es[3] = S_OFF;
      do_reset();
      data     = 16'h12AF;
      digit_en = 4'b0101;
      load     = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i > 0) step();
         k  = (i / 4) % 4;
         ea = 4'b1111;
         if (k == 0 || k == 2) ea[k] = 1'b0;
         tests++;
         if (an !== ea || sseg !== es[k]) begin
            fails++;
            $display("FAIL digit_en cyc %0d: an=%b sseg=%b, want %b %b", i, an, sseg, ea, es[k]);
         end
      end
      digit_en = 4'hF;
   endtask

   task automatic test_lead_zero();
      logic [3:0] ea;
      logic [6:0] es [4];
      int         k;
      logic       lit;
      // 16'h0005
      do_reset();
      data     = 16'h0005;
      digit_en = 4'hF;
      load     = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step();
         k = i / 4;
`ifdef LEAD_ZERO_BLANK_EN
         lit = (k == 0);
`else
         lit = 1'b1;
`endif
         ea = 4'b1111;
         if (lit) ea[k] = 1'b0;
         es[k] = !lit ? S_OFF : (k == 0 ? S_5 : S_0);
         tests++;
         if (an !== ea || sseg !== es[k]) begin
            fails++;
            $display("FAIL lead_zero_0005 cyc %0d: an=%b sseg=%b, want %b %b", i, an, sseg, ea, es[k]);
         end
      end
      // 16'h0000
      do_reset();
      data = 16'h0000;
      load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step();
         k = i / 4;
`ifdef LEAD_ZERO_BLANK_EN
         lit = (k == 0);
`else
         lit = 1'b1;
`endif
         ea = 4'b1111;
         if (lit) ea[k] = 1'b0;
         es[k] = lit ? S_0 : S_OFF;
         tests++;
         if (an !== ea || sseg !== es[k]) begin
            fails++;
            $display("FAIL lead_zero_0000 cyc %0d: an=%b sseg=%b, want %b %b", i, an, sseg, ea, es[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      data     = 16'h12AF;
      digit_en = 4'hF;
      load     = 1'b1;
      step();
      load = 1'b0;
      step();
      step();
      step();
      data = 16'h3456;
      load = 1'b1;
      step();
      tests++;
      if (an !== 4'b1101 || sseg !== S_5 || strobe !== 1'b1) begin
         fails++;
         $display("FAIL bypass_tick: an=%b sseg=%b strobe=%b, want 1101 %b 1", an, sseg, strobe, S_5);
      end
      load = 1'b0;
      for (int i = 0; i < 4; i++) step();
      tests++;
      if (an !== 4'b1011 || sseg !== S_4 || strobe !== 1'b1) begin
         fails++;
         $display("FAIL bypass_next: an=%b sseg=%b strobe=%b, want 1011 %b 1", an, sseg, strobe, S_4);
      end
      for (int i = 0; i < 4; i++) step();
      tests++;
      if (an !== 4'b0111 || sseg !== S_3 || strobe !== 1'b1) begin
         fails++;
         $display("FAIL bypass_slot3: an=%b sseg=%b strobe=%b, want 0111 %b 1", an, sseg, strobe, S_3);
      end
      step();
      step();
      tests++;
      if (strobe !== 1'b0) begin
         fails++;
         $display("FAIL bypass_strobe_end: strobe=%b, want 0", strobe);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      data     = 16'h12AF;
      digit_en = 4'hF;
      load     = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 5; i++) step();
      rst_n = 1'b0;
      step();
      tests++;
      if (an !== 4'b1111 || sseg !== S_OFF || strobe !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: an=%b sseg=%b strobe=%b, want 1111 1111111 0", an, sseg, strobe);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         tests++;
         if (an !== 4'b1111 || sseg !== S_OFF || strobe !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_idle cyc %0d: an=%b sseg=%b strobe=%b, want 1111 1111111 0",
                     i, an, sseg, strobe);
         end
      end
      data = 16'h0003;
      load = 1'b1;
      step();
      tests++;
      if (an !== 4'b1110 || sseg !== S_3 || strobe !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_reload: an=%b sseg=%b strobe=%b, want 1110 %b 1", an, sseg, strobe, S_3);
      end
      load = 1'b0;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      rst_n    = 1'b0;
      data     = 16'h0000;
      digit_en = 4'hF;
      load     = 1'b0;
      test_reset();
      test_scan_basic();
      test_retrigger();
      test_digit_en();
      test_lead_zero();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
